inst_queue: RTL

- Fetch-side instruction queue directly downstream of the second cache-trace stage.
- Each cycle it accepts one 4-word fetch group and compacts the enabled lanes into a circular buffer.
- It presents up to 2 oldest instructions per cycle to decode, which sets how many are consumed.
- Decouples fetch-group bursts from the 2-wide decode and absorbs the one in-flight group that cannot be stalled once inst_data_ok fires.

---
 rtl/inst_queue_pkg.sv | 26 ++
 rtl/inst_queue_compactor.sv | 43 ++++
 rtl/inst_queue.sv | 136 +++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-side instruction queue.
// Optional perf counters are enabled by defining IQ_PERF_CNT_EN.
package inst_queue_pkg;

    localparam int IQ_ENTRY_W = 104;
    localparam int IQ_DEPTH   = 16;
    localparam int IQ_LANES   = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_take;
        logic [31:0] pred_dest;
        logic        has_exc;
        logic [4:0]  exc_code;
        logic        is_refill;
    } iq_entry_t;

    // Lane enables must form a single contiguous run of ones.
    function automatic logic en_legal(input logic [3:0] en);
        return en inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                          4'b1000, 4'b0011, 4'b0110, 4'b1100,
                          4'b0111, 4'b1110, 4'b1111};
    endfunction

endpackage

// File: rtl/inst_queue_compactor.sv
// Packs the enabled lanes of one fetch group into consecutive entries.
// Exception groups keep only their lowest enabled lane, with inst zeroed.
module iq_compactor
    import inst_queue_pkg::*;
(
    input  logic                   i_valid,
    input  logic [27:0]            i_vaddr_hi,
    input  logic [3:0]             i_en,
    input  logic [127:0]           i_rdata,
    input  logic [3:0]             i_pred_take,
    input  logic [127:0]           i_pred_dest,
    input  logic                   i_has_exc,
    input  logic [4:0]             i_exc_code,
    input  logic                   i_is_refill,
    output logic [2:0]             o_push_num,
    output iq_entry_t [IQ_LANES-1:0] o_ent
);

    logic [2:0]                  w_num;
    iq_entry_t [IQ_LANES-1:0]    w_ent;

    always_comb begin
        w_num = '0;
        w_ent = '0;
        for (int i = 0; i < IQ_LANES; i++) begin
            if (i_valid && i_en[i] && !(i_has_exc && w_num != 3'd0)) begin
                w_ent[w_num[1:0]].pc        = {i_vaddr_hi, 2'(i), 2'b00};
                w_ent[w_num[1:0]].inst      = i_has_exc ? 32'd0
                                                        : i_rdata[32*i +: 32];
                w_ent[w_num[1:0]].pred_take = i_pred_take[i];
                w_ent[w_num[1:0]].pred_dest = i_pred_dest[32*i +: 32];
                w_ent[w_num[1:0]].has_exc   = i_has_exc;
                w_ent[w_num[1:0]].exc_code  = i_has_exc ? i_exc_code : 5'd0;
                w_ent[w_num[1:0]].is_refill = i_has_exc & i_is_refill;
                w_num = w_num + 3'd1;
            end
        end
    end

    assign o_push_num = w_num;
    assign o_ent      = w_ent;

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and 2-wide decode.
// Define IQ_PERF_CNT_EN to add empty/stall cycle counters.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         SCT_valid_i,
    input  logic [31:0]  SCT_VAddr_i,
    input  logic [3:0]   SCT_originEnable_i,
    input  logic [127:0] inst_rdata_i,
    input  logic [3:0]   SCT_predTake_p_i,
    input  logic [127:0] SCT_predDest_p_i,
    input  logic         SCT_hasException_i,
    input  logic [4:0]   SCT_ExcCode_i,
    input  logic         SCT_isRefill_i,
    output logic         IQ_allowin_o,
    output logic [1:0]   IQ_valid_o,
    output logic [63:0]  IQ_inst_o,
    output logic [63:0]  IQ_pc_o,
    output logic [1:0]   IQ_predTake_o,
    output logic [63:0]  IQ_predDest_o,
    output logic [1:0]   IQ_hasException_o,
    output logic [9:0]   IQ_ExcCode_o,
    output logic [1:0]   IQ_isRefill_o,
`ifdef IQ_PERF_CNT_EN
    output logic [31:0]  IQ_emptyCycles_o,
    output logic [31:0]  IQ_stallCycles_o,
`endif
    input  logic [1:0]   ID_popNum_i
);

    localparam int CNT_W = PTR_W + 1;

    iq_entry_t                 r_mem [DEPTH];
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;
    logic [2:0]                w_push_num;
    iq_entry_t [IQ_LANES-1:0]  w_ent;
    iq_entry_t                 w_s0;
    iq_entry_t                 w_s1;
    logic                      w_unused_vaddr;

    assign w_unused_vaddr = ^SCT_VAddr_i[3:0];

    iq_compactor u_comp (
        .i_valid     (SCT_valid_i),
        .i_vaddr_hi  (SCT_VAddr_i[31:4]),
        .i_en        (SCT_originEnable_i),
        .i_rdata     (inst_rdata_i),
        .i_pred_take (SCT_predTake_p_i),
        .i_pred_dest (SCT_predDest_p_i),
        .i_has_exc   (SCT_hasException_i),
        .i_exc_code  (SCT_ExcCode_i),
        .i_is_refill (SCT_isRefill_i),
        .o_push_num  (w_push_num),
        .o_ent       (w_ent)
    );

    always_ff @(posedge clk) begin
        if (!flush_i) begin
            for (int k = 0; k < IQ_LANES; k++) begin
                if (3'(k) < w_push_num)
                    r_mem[r_tail + PTR_W'(k)] <= w_ent[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(ID_popNum_i);
            r_tail  <= r_tail + PTR_W'(w_push_num);
            r_count <= r_count + CNT_W'(w_push_num)
                               - CNT_W'(ID_popNum_i);
        end
    end

    assign w_s0 = (r_count != '0) ? r_mem[r_head] : '0;
    assign w_s1 = (r_count >= CNT_W'(2)) ? r_mem[r_head + PTR_W'(1)] : '0;

    // Eight free slots cover the arriving group plus one in flight.
    assign IQ_allowin_o      = (r_count <= CNT_W'(DEPTH - 8));
    assign IQ_valid_o        = {r_count >= CNT_W'(2), r_count != '0};
    assign IQ_inst_o         = {w_s1.inst, w_s0.inst};
    assign IQ_pc_o           = {w_s1.pc, w_s0.pc};
    assign IQ_predTake_o     = {w_s1.pred_take, w_s0.pred_take};
    assign IQ_predDest_o     = {w_s1.pred_dest, w_s0.pred_dest};
    assign IQ_hasException_o = {w_s1.has_exc, w_s0.has_exc};
    assign IQ_ExcCode_o      = {w_s1.exc_code, w_s0.exc_code};
    assign IQ_isRefill_o     = {w_s1.is_refill, w_s0.is_refill};

`ifdef IQ_PERF_CNT_EN
    logic [31:0] r_empty_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_empty_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_count == '0 && !flush_i && r_empty_cnt != '1)
                r_empty_cnt <= r_empty_cnt + 32'd1;
            if (!IQ_allowin_o && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign IQ_emptyCycles_o = r_empty_cnt;
    assign IQ_stallCycles_o = r_stall_cnt;
`endif

    a_en_legal: assert property (@(posedge clk) disable iff (!rst)
        SCT_valid_i |-> en_legal(SCT_originEnable_i));

    a_no_ovf: assert property (@(posedge clk) disable iff (!rst)
        !flush_i |-> ({1'b0, r_count} + (CNT_W+1)'(w_push_num)
                      <= (CNT_W+1)'(DEPTH)));

    a_pop_ok: assert property (@(posedge clk) disable iff (!rst)
        !flush_i |-> (ID_popNum_i != 2'd3
                      && CNT_W'(ID_popNum_i) <= r_count));

endmodule
